// File: rtl/alu_control_pkg.sv
// alu_control_pkg: shared ALU control encodings, funct codes, alu_op classes and FSM state type.
package alu_control_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_XOR = 4'b1101;
    localparam logic [3:0] CTRL_SLL = 4'b1000;
    localparam logic [3:0] CTRL_SRL = 4'b1001;
    localparam logic [3:0] CTRL_SRA = 4'b1010;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;

    localparam logic [2:0] ALUOP_MEM   = 3'b000;
    localparam logic [2:0] ALUOP_BR    = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_ANDI  = 3'b011;
    localparam logic [2:0] ALUOP_ORI   = 3'b100;
    localparam logic [2:0] ALUOP_SLTI  = 3'b101;
    localparam logic [2:0] ALUOP_XORI  = 3'b110;

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

endpackage

// File: rtl/alu_control_decode.sv
// alu_control_decode: combinational funct/alu_op decode to an ALU control word plus error flags.
// Shift functs (sll/srl/sra) are legal only when SHIFT_OPS_EN is defined.
module alu_control_decode
    import alu_control_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3
) (
    input  logic [5:0]              func,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [3:0]              ctrl,
    output logic                    err_func,
    output logic                    err_op
);

    // The all-ones op code is the illegal class at either width.
    localparam logic [2:0] OP_ILL = 3'((1 << ALU_OP_WIDTH) - 1);

    logic [2:0] op;
    logic [3:0] fctrl;
    logic       fbad;

    assign op = 3'(alu_op);

    always_comb begin
        fbad  = 1'b0;
        fctrl = CTRL_ADD;
        case (func)
            FUNCT_ADD, FUNCT_ADDU: fctrl = CTRL_ADD;
            FUNCT_SUB, FUNCT_SUBU: fctrl = CTRL_SUB;
            FUNCT_AND:             fctrl = CTRL_AND;
            FUNCT_OR:              fctrl = CTRL_OR;
            FUNCT_XOR:             fctrl = CTRL_XOR;
            FUNCT_NOR:             fctrl = CTRL_NOR;
            FUNCT_SLT:             fctrl = CTRL_SLT;
`ifdef SHIFT_OPS_EN
            FUNCT_SLL:             fctrl = CTRL_SLL;
            FUNCT_SRL:             fctrl = CTRL_SRL;
            FUNCT_SRA:             fctrl = CTRL_SRA;
`endif
            default:               fbad  = 1'b1;
        endcase
    end

    always_comb begin
        err_op   = op == OP_ILL;
        err_func = !err_op && op == ALUOP_RTYPE && fbad;
        case (op)
            ALUOP_MEM:   ctrl = CTRL_ADD;
            ALUOP_BR:    ctrl = CTRL_SUB;
            ALUOP_RTYPE: ctrl = fctrl;
            ALUOP_ANDI:  ctrl = CTRL_AND;
            ALUOP_ORI:   ctrl = CTRL_OR;
            ALUOP_SLTI:  ctrl = CTRL_SLT;
            ALUOP_XORI:  ctrl = CTRL_XOR;
            default:     ctrl = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control decoder (IDLE/DECODE/DONE) with error flags and saturating error count.
// Optional shift functs via SHIFT_OPS_EN (handled in alu_control_decode).
module alu_control_seq
    import alu_control_pkg::*;
#(
    parameter int         ALU_OP_WIDTH  = 3,
    parameter int         ERR_CNT_WIDTH = 8,
    parameter logic [3:0] CTRL_DEFAULT  = 4'b0010
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [5:0]               func,
    input  logic [ALU_OP_WIDTH-1:0]  alu_op,
    output logic                     busy,
    output logic                     finish,
    output logic [3:0]               alu_control,
    output logic                     err_illegal_func_code,
    output logic                     err_illegal_alu_op,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    state_t                   state_q;
    logic [5:0]               func_q;
    logic [ALU_OP_WIDTH-1:0]  op_q;
    logic                     busy_q, finish_q, err_func_q, err_op_q;
    logic [3:0]               ctrl_q, ctrl_raw, ctrl_d;
    logic                     err_func_d, err_op_d, err_any;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    alu_control_decode #(.ALU_OP_WIDTH(ALU_OP_WIDTH)) u_decode (
        .func     (func_q),
        .alu_op   (op_q),
        .ctrl     (ctrl_raw),
        .err_func (err_func_d),
        .err_op   (err_op_d)
    );

    always_comb begin
        err_any = err_func_d | err_op_d;
        ctrl_d  = err_any ? CTRL_DEFAULT : ctrl_raw;
        cnt_d   = (err_any && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            func_q     <= '0;
            op_q       <= '0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            ctrl_q     <= CTRL_DEFAULT;
            err_func_q <= 1'b0;
            err_op_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        func_q <= func;
                        op_q   <= alu_op;
                    end
                    state_q <= start ? DECODE : IDLE;
                    busy_q  <= start;
                end
                DECODE: begin
                    ctrl_q     <= ctrl_d;
                    err_func_q <= err_func_d;
                    err_op_q   <= err_op_d;
                    cnt_q      <= cnt_d;
                    finish_q   <= 1'b1;
                    state_q    <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy                  = busy_q;
    assign finish                = finish_q;
    assign alu_control           = ctrl_q;
    assign err_illegal_func_code = err_func_q;
    assign err_illegal_alu_op    = err_op_q;
    assign err_count             = cnt_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: scoreboard bench for alu_control_seq, default build plus a 2-bit op / 2-bit counter instance.
module tb_alu_control_seq;

    typedef struct {
        logic [3:0] ctrl;
        logic       ef;
        logic       eo;
        int         cnt;
        int         t;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [5:0] func = '0;
    logic [2:0] alu_op = '0;

    logic       busy, finish, eff, eop;
    logic [3:0] alu_control;
    logic [7:0] err_count;
    logic       busy_s, finish_s, eff_s, eop_s;
    logic [3:0] ctrl_s;
    logic [1:0] cnt_s_o;

    alu_control_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .alu_op(alu_op),
        .busy(busy), .finish(finish), .alu_control(alu_control),
        .err_illegal_func_code(eff), .err_illegal_alu_op(eop), .err_count(err_count)
    );

    alu_control_seq #(.ALU_OP_WIDTH(2), .ERR_CNT_WIDTH(2)) u_small (
        .clk(clk), .rst(rst), .start(start), .func(func), .alu_op(alu_op[1:0]),
        .busy(busy_s), .finish(finish_s), .alu_control(ctrl_s),
        .err_illegal_func_code(eff_s), .err_illegal_alu_op(eop_s), .err_count(cnt_s_o)
    );

    always #5 clk = ~clk;

    exp_t q[$], qs[$];
    exp_t dflt = '{4'b0010, 1'b0, 1'b0, 0, 0};
    exp_t held = '{4'b0010, 1'b0, 1'b0, 0, 0};
    exp_t held_s = '{4'b0010, 1'b0, 1'b0, 0, 0};
    exp_t e, es;
    int checks = 0, errors = 0, cyc = 0, last_acc = -100, cnt = 0, cnt_s = 0;
    bit gap = 1'b0, due, due_s;
    logic [5:0] legal [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Reference decode: what the ALU should do for a request, from the op class and funct tables.
    function automatic exp_t model(input logic [5:0] f, input logic [2:0] op, input int w);
        exp_t r = '{4'b0010, 1'b0, 1'b0, 0, 0};
        if (op == 3'd7 || (w == 2 && op == 3'd3)) r.eo = 1'b1;
        else if (op == 3'd2) begin
            case (f)
                6'b100000, 6'b100001: r.ctrl = 4'b0010;
                6'b100010, 6'b100011: r.ctrl = 4'b0110;
                6'b100100: r.ctrl = 4'b0000;
                6'b100101: r.ctrl = 4'b0001;
                6'b100110: r.ctrl = 4'b1101;
                6'b100111: r.ctrl = 4'b1100;
                6'b101010: r.ctrl = 4'b0111;
`ifdef SHIFT_OPS_EN
                6'b000000: r.ctrl = 4'b1000;
                6'b000010: r.ctrl = 4'b1001;
                6'b000011: r.ctrl = 4'b1010;
`endif
                default:   r.ef = 1'b1;
            endcase
        end else begin
            case (op)
                3'd0: r.ctrl = 4'b0010;
                3'd1: r.ctrl = 4'b0110;
                3'd3: r.ctrl = 4'b0000;
                3'd4: r.ctrl = 4'b0001;
                3'd5: r.ctrl = 4'b0111;
                default: r.ctrl = 4'b1101;
            endcase
        end
        return r;
    endfunction

    // Acceptance model: a request occupies two edges, so the edge right after an accept ignores start.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            cnt = 0; cnt_s = 0; gap = 1'b0; last_acc = -100;
        end else if (start && !gap) begin
            e = model(func, alu_op, 3);
            if ((e.ef || e.eo) && cnt < 255) cnt++;
            e.cnt = cnt; e.t = cyc; q.push_back(e);
            es = model(func, {1'b0, alu_op[1:0]}, 2);
            if ((es.ef || es.eo) && cnt_s < 3) cnt_s++;
            es.cnt = cnt_s; es.t = cyc; qs.push_back(es);
            last_acc = cyc; gap = 1'b1;
        end else gap = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            q.delete(); qs.delete(); held = dflt; held_s = dflt;
        end else begin
            due = q.size() != 0 && cyc >= q[0].t + 1;
            chk("finish", finish, due);
            if (finish && due) begin
                held = q.pop_front();
                chk("latency", cyc, held.t + 1);
            end
            chk("alu_control", alu_control, held.ctrl);
            chk("err_func", eff, held.ef);
            chk("err_op", eop, held.eo);
            chk("err_count", err_count, held.cnt);
            chk("busy", busy, (cyc - last_acc) <= 1);
            due_s = qs.size() != 0 && cyc >= qs[0].t + 1;
            chk("s_finish", finish_s, due_s);
            if (finish_s && due_s) held_s = qs.pop_front();
            chk("s_alu_control", ctrl_s, held_s.ctrl);
            chk("s_err_func", eff_s, held_s.ef);
            chk("s_err_op", eop_s, held_s.eo);
            chk("s_err_count", cnt_s_o, held_s.cnt);
            chk("s_busy", busy_s, (cyc - last_acc) <= 1);
        end
    end

    task automatic issue(input logic [5:0] f, input logic [2:0] op);
        start = 1'b1; func = f; alu_op = op;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(6'b100000, 3'd0);
        foreach (legal[i]) issue(legal[i], 3'd2);
        issue(6'b111010, 3'd2);
        issue(6'b100000, 3'd7);
        issue(6'b000010, 3'd2);
        issue(6'b000000, 3'd2);
        issue(6'b000011, 3'd2);
        for (int o = 0; o < 8; o++) issue(6'($urandom), 3'(o));
        repeat (5) issue(6'b111111, 3'd2);
        @(negedge clk);
        chk("small_saturated", cnt_s_o, 2'd3);
        @(posedge clk); #1;
        // Held start: accepted, ignored in DECODE, accepted again in DONE.
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; func = 6'($urandom); alu_op = 3'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4000; i++) begin
            start  = 1'($urandom_range(0, 1));
            func   = ($urandom_range(0, 1) == 0) ? 6'($urandom) : legal[$urandom_range(0, 6)];
            alu_op = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("main_saturated", err_count, 8'hff);
        @(posedge clk); #1;
        start = 1'b1; func = 6'b100000; alu_op = 3'd7;
        @(posedge clk); #1 start = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_finish", finish, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_count", err_count, 8'd0);
        @(posedge clk); #1;
        issue(6'b101010, 3'd2);
        issue(6'b000001, 3'd2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drained", q.size() + qs.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
